ahb_master: RTL and testbench

- AHB-Lite bus master; it is the initiator-side counterpart of ahb_slave.
- It converts a local command/data handshake into pipelined AHB-Lite address and data phases.
- It supports SINGLE, INCR4, INCR8 and INCR16 bursts, inserts BUSY when write data is late, and aborts a burst on a two-cycle ERROR response.
- It sits between a local engine (DMA, test driver) and the interconnect feeding ahb_slave.

---
 rtl/ahb_master.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_ahb_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master.sv
// AHB-Lite bus master. Turns a local command / write-data / read-data
// handshake into pipelined AHB-Lite address and data phases. It handles
// SINGLE and INCR4/8/16 bursts, inserts BUSY when write data is late, and
// abandons a burst on a two-cycle ERROR response.
module ahb_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter logic       LOCK_VAL  = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  // local command interface
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_len,
  // local write-data interface
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  // local read-data and status
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  // AHB-Lite master interface
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HMASTERLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // FSM and burst bookkeeping
  logic [1:0]  state_q,    state_d;
  logic [4:0]  beat_q,     beat_d;     // beats whose address has been issued
  logic [4:0]  nbeats_q,   nbeats_d;   // total beats in the current burst
  // registered AHB address-phase outputs
  logic [31:0] haddr_q,    haddr_d;
  logic [1:0]  htrans_q,   htrans_d;
  logic        hwrite_q,   hwrite_d;
  logic [2:0]  hsize_q,    hsize_d;
  logic [2:0]  hburst_q,   hburst_d;
  logic [31:0] hwdata_q,   hwdata_d;
  // write data taken from the local side, waiting for its data phase
  logic [31:0] hold_q,     hold_d;
  // beat currently in its data phase
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  // registered local outputs
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q,  rd_data_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;

  // command decode
  logic [4:0]  cmd_beats;
  logic [2:0]  cmd_burst;
  logic [10:0] cmd_bytes;
  logic [10:0] cmd_end;
  logic        size_ok;
  logic        cmd_ok;
  logic        accept;

  // pipeline helpers
  logic        addr_active;
  logic        more_beats;
  logic        err_now;
  logic        issue_slot;
  logic        wr_take;
  logic [31:0] incr;
  logic [31:0] next_addr;

  // Decode the incoming command: beat count, HBURST code, legality.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    cmd_beats = 5'd1;
    cmd_burst = 3'b000;
    size_ok   = 1'b0;
    case (cmd_len)
      2'b00: begin cmd_beats = 5'd1;  cmd_burst = 3'b000; end
      2'b01: begin cmd_beats = 5'd4;  cmd_burst = 3'b011; end
      2'b10: begin cmd_beats = 5'd8;  cmd_burst = 3'b101; end
      default: begin cmd_beats = 5'd16; cmd_burst = 3'b111; end
    endcase
    case (cmd_size)
      3'd0:    size_ok = 1'b1;
      3'd1:    size_ok = ~cmd_addr[0];
      3'd2:    size_ok = (cmd_addr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
    // At most 16 beats of 4 bytes, so 11 bits cannot overflow here.
    cmd_bytes = 11'(cmd_beats) << cmd_size[1:0];
    cmd_end   = {1'b0, cmd_addr[9:0]} + cmd_bytes;
    cmd_ok    = size_ok && (cmd_end <= 11'd1024);
  end

  assign accept      = cmd_valid && (state_q == S_IDLE);
  assign addr_active = (htrans_q == TR_NONSEQ) || (htrans_q == TR_SEQ);
  assign more_beats  = (beat_q != nbeats_q);
  assign err_now     = dp_valid_q && HRESP;
  assign incr        = 32'd1 << hsize_q[1:0];
  // BUSY and the pre-burst IDLE already present the address of the next beat.
  assign next_addr   = addr_active ? (haddr_q + incr) : haddr_q;
  // A cycle in which a new beat address may be launched mid-burst.
  assign issue_slot  = (state_q == S_ADDR) && HREADY && !err_now && more_beats;

  // Write-data handshake: taken in the cycle the beat's address is launched.
  always_comb begin
    wr_take = 1'b0;
    if (state_q == S_IDLE) begin
      wr_take = accept && cmd_ok && cmd_write && wr_valid;
    end else begin
      wr_take = issue_slot && hwrite_q && wr_valid;
    end
  end

  // Next-state logic for the FSM, address phase and data phase.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    nbeats_d   = nbeats_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    hold_d     = hold_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (wr_take) begin
      hold_d = wr_data;
    end

    // Pipeline advance: the accepted address phase becomes the data phase,
    // and the finishing data phase returns read data.
    if (HREADY) begin
      dp_valid_d = addr_active;
      dp_write_d = hwrite_q;
      if (addr_active && hwrite_q) begin
        hwdata_d = hold_q;
      end
      if (dp_valid_q && !dp_write_q && !HRESP && (state_q != S_ERR)) begin
        rd_valid_d = 1'b1;
        rd_data_d  = HRDATA;
      end
    end

    if (((state_q == S_ADDR) || (state_q == S_LAST)) && err_now) begin
      // First ERROR cycle: cancel any pending address at once.
      htrans_d = TR_IDLE;
      if (HREADY) begin
        err_d      = 1'b1;
        state_d    = S_IDLE;
        beat_d     = 5'd0;
        dp_valid_d = 1'b0;
      end else begin
        state_d = S_ERR;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!cmd_ok) begin
              err_d = 1'b1;
            end else begin
              state_d  = S_ADDR;
              nbeats_d = cmd_beats;
              haddr_d  = cmd_addr;
              hwrite_d = cmd_write;
              hsize_d  = cmd_size;
              hburst_d = cmd_burst;
              if (!cmd_write || wr_valid) begin
                htrans_d = TR_NONSEQ;
                beat_d   = 5'd1;
              end else begin
                htrans_d = TR_IDLE;
                beat_d   = 5'd0;
              end
            end
          end
        end

        S_ADDR: begin
          if (HREADY) begin
            if (!more_beats) begin
              // Final address accepted; only its data phase remains.
              htrans_d = TR_IDLE;
              state_d  = S_LAST;
            end else begin
              haddr_d = next_addr;
              if (!hwrite_q || wr_valid) begin
                htrans_d = (beat_q == 5'd0) ? TR_NONSEQ : TR_SEQ;
                beat_d   = beat_q + 5'd1;
              end else begin
                htrans_d = (beat_q == 5'd0) ? TR_IDLE : TR_BUSY;
              end
            end
          end
        end

        S_LAST: begin
          if (HREADY) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            beat_d  = 5'd0;
          end
        end

        S_ERR: begin
          // Second ERROR cycle ends the command; remaining beats are dropped.
          if (HREADY) begin
            err_d      = 1'b1;
            state_d    = S_IDLE;
            beat_d     = 5'd0;
            htrans_d   = TR_IDLE;
            dp_valid_d = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset; a reset abandons any burst silently.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (HRESET) begin
      state_q    <= S_IDLE;
      beat_q     <= 5'd0;
      nbeats_q   <= 5'd0;
      haddr_q    <= 32'd0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      hburst_q   <= 3'd0;
      hwdata_q   <= 32'd0;
      hold_q     <= 32'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      nbeats_q   <= nbeats_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      hold_q     <= hold_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign wr_ready    = wr_take;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;
  assign err         = err_q;

  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HPROT       = HPROT_VAL;
  assign HTRANS      = htrans_q;
  assign HMASTERLOCK = LOCK_VAL;
  assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed testbench for ahb_master. The bench plays the AHB slave by
// driving HREADY/HRESP/HRDATA cycle by cycle and compares every observed
// output against hand-computed expectations.
module tb_ahb_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTERLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;
  int rd_seen;

  // INCR8 read from 0x0, two wait states in beat 3's data phase (cycles 5,6).
  logic [31:0] t3_tr [12] = '{2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0};
  logic [31:0] t3_ad [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h10,
                              32'h10, 32'h14, 32'h18, 32'h1C, 32'h1C, 32'h1C};
  logic [31:0] t3_rd [8]  = '{32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004, 32'hC0DE0007,
                              32'hC0DE0008, 32'hC0DE0009, 32'hC0DE000A, 32'hC0DE000B};

  // INCR4 write at 0x200, wr_valid low for two cycles before beat 2.
  logic [31:0] t4_wv [8]  = '{1, 0, 0, 1, 1, 0, 0, 0};
  logic [31:0] t4_wd [8]  = '{32'h22, 0, 0, 32'h33, 32'h44, 0, 0, 0};
  logic [31:0] t4_tr [8]  = '{2, 3, 1, 1, 3, 3, 0, 0};
  logic [31:0] t4_ad [8]  = '{32'h200, 32'h204, 32'h208, 32'h208,
                              32'h208, 32'h20C, 32'h20C, 32'h20C};
  logic [31:0] t4_hw [8]  = '{0, 32'h11, 32'h22, 32'h22, 32'h22, 32'h33, 32'h44, 32'h44};
  logic [31:0] t4_wr [8]  = '{1, 0, 0, 1, 1, 0, 0, 0};

  // INCR16 read at 0x40, ERROR on beat 5 (first ERROR cycle is cycle 7).
  logic [31:0] t5_tr [10] = '{2, 3, 3, 3, 3, 3, 3, 0, 0, 0};
  logic [31:0] t5_ad [10] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50,
                              32'h54, 32'h58, 32'h58, 32'h58, 32'h58};

  ahb_master dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .done        (done),
    .err         (err),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HTRANS      (HTRANS),
    .HMASTERLOCK (HMASTERLOCK),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling/driving.
  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    HRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'd0;
    cmd_size  = 3'd0;
    cmd_len   = 2'b00;
    wr_valid  = 1'b0;
    wr_data   = 32'd0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'd0;

    // ---------------- reset state
    step();
    step();
    check("rst_htrans",    32'(HTRANS),      32'd0);
    check("rst_haddr",     HADDR,            32'd0);
    check("rst_hburst",    32'(HBURST),      32'd0);
    check("rst_cmd_ready", 32'(cmd_ready),   32'd1);
    check("rst_done_err",  32'({done, err, rd_valid, wr_ready}), 32'd0);
    check("hprot",         32'(HPROT),       32'h3);
    check("hmasterlock",   32'(HMASTERLOCK), 32'd0);
    HRESET = 1'b0;

    // ---------------- 1: single read at 0x100
    step();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_size = 3'd2; cmd_len = 2'b00;
    check("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    step();                                      // T+1
    cmd_valid = 1'b0;
    check("t1_htrans", 32'(HTRANS), 32'd2);
    check("t1_haddr",  HADDR,       32'h100);
    check("t1_hburst", 32'(HBURST), 32'd0);
    check("t1_hsize",  32'(HSIZE),  32'd2);
    check("t1_hwrite", 32'(HWRITE), 32'd0);
    check("t1_busy_cmd_ready", 32'(cmd_ready), 32'd0);
    step();                                      // T+2: data phase
    HRDATA = 32'hDEADBEEF;
    check("t1_last_htrans", 32'(HTRANS),   32'd0);
    check("t1_rd_early",    32'(rd_valid), 32'd0);
    step();                                      // T+3
    HRDATA = 32'd0;
    check("t1_rd_valid", 32'(rd_valid), 32'd1);
    check("t1_rd_data",  rd_data,       32'hDEADBEEF);
    check("t1_done",     32'(done),     32'd1);
    check("t1_err",      32'(err),      32'd0);
    step();
    check("t1_done_clr",  32'(done),      32'd0);
    check("t1_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- 2: INCR4 write at 0x200, data always ready
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_size = 3'd2; cmd_len = 2'b01;
    wr_valid = 1'b1; wr_data = 32'd1;
    #1;
    check("t2_wr_ready0", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();                                    // T+1+i: address of beat i
      cmd_valid = 1'b0;
      check("t2_htrans", 32'(HTRANS), (i == 0) ? 32'd2 : 32'd3);
      check("t2_haddr",  HADDR,       32'h200 + 32'(4 * i));
      check("t2_hburst", 32'(HBURST), 32'b011);
      if (i > 0) check("t2_hwdata", HWDATA, 32'(i));
      if (i < 3) begin
        wr_data = 32'(i + 2);
        #1;
        check("t2_wr_ready", 32'(wr_ready), 32'd1);
      end else begin
        wr_valid = 1'b0;
        #1;
        check("t2_wr_ready_end", 32'(wr_ready), 32'd0);
      end
    end
    step();                                      // T+5
    check("t2_last_htrans", 32'(HTRANS), 32'd0);
    check("t2_hwdata4",     HWDATA,      32'd4);
    check("t2_done_early",  32'(done),   32'd0);
    step();                                      // T+6
    check("t2_done", 32'(done), 32'd1);
    check("t2_err",  32'(err),  32'd0);
    step();

    // ---------------- 3: INCR8 read at 0x0 with two wait states on beat 3
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd2; cmd_len = 2'b10;
    step();
    cmd_valid = 1'b0;
    rd_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      HREADY = !((k == 5) || (k == 6));
      HRDATA = 32'hC0DE0000 + 32'(k);
      check("t3_htrans", 32'(HTRANS), t3_tr[k-1]);
      check("t3_haddr",  HADDR,       t3_ad[k-1]);
      check("t3_done",   32'(done),   32'(k == 12));
      if (rd_valid && (rd_seen < 8)) begin
        check("t3_rd_data", rd_data, t3_rd[rd_seen]);
        rd_seen++;
      end
    end
    HREADY = 1'b1;
    HRDATA = 32'd0;
    check("t3_rd_count", 32'(rd_seen), 32'd8);
    step();

    // ---------------- 4: INCR4 write with late data before beat 2
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_size = 3'd2; cmd_len = 2'b01;
    wr_valid = 1'b1; wr_data = 32'h11;
    #1;
    check("t4_wr_ready0", 32'(wr_ready), 32'd1);
    for (int j = 0; j < 8; j++) begin
      step();
      cmd_valid = 1'b0;
      wr_valid  = t4_wv[j][0];
      wr_data   = t4_wd[j];
      #1;
      check("t4_htrans",   32'(HTRANS),   t4_tr[j]);
      check("t4_haddr",    HADDR,         t4_ad[j]);
      check("t4_wr_ready", 32'(wr_ready), t4_wr[j]);
      check("t4_done",     32'(done),     32'(j == 7));
      if (j > 0) check("t4_hwdata", HWDATA, t4_hw[j]);
    end
    step();

    // ---------------- 5: INCR16 read at 0x40, ERROR on beat 5
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_size = 3'd2; cmd_len = 2'b11;
    step();
    cmd_valid = 1'b0;
    rd_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) step();
      HREADY = (k != 7);
      HRESP  = (k == 7) || (k == 8);
      HRDATA = 32'h50000000 + 32'(k);
      check("t5_htrans",   32'(HTRANS),   t5_tr[k-1]);
      check("t5_haddr",    HADDR,         t5_ad[k-1]);
      check("t5_rd_valid", 32'(rd_valid), 32'((k >= 3) && (k <= 7)));
      if ((k >= 3) && (k <= 7)) check("t5_rd_data", rd_data, 32'h50000000 + 32'(k - 1));
      check("t5_err",      32'(err),      32'(k == 9));
      check("t5_done",     32'(done),     32'd0);
      if (rd_valid) rd_seen++;
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'd0;
    check("t5_rd_count",  32'(rd_seen),   32'd5);
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- 6: 1 KB crossing is rejected
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3F8; cmd_size = 3'd2; cmd_len = 2'b01;
    step();                                      // T+1
    cmd_valid = 1'b0;
    check("t6_err",       32'(err),       32'd1);
    check("t6_htrans",    32'(HTRANS),    32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    step();                                      // T+2
    check("t6_err_clr",   32'(err),       32'd0);
    check("t6_htrans2",   32'(HTRANS),    32'd0);
    check("t6_done",      32'(done),      32'd0);

    // ---------------- reset in the middle of a write burst
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_size = 3'd2; cmd_len = 2'b01;
    wr_valid = 1'b1; wr_data = 32'hAAAA0001;
    step();                                      // T+1
    cmd_valid = 1'b0;
    wr_data = 32'hAAAA0002;
    check("rm_htrans", 32'(HTRANS), 32'd2);
    check("rm_hwrite", 32'(HWRITE), 32'd1);
    step();                                      // T+2
    check("rm_haddr",  HADDR,  32'h304);
    check("rm_hwdata", HWDATA, 32'hAAAA0001);
    HRESET = 1'b1;
    step();                                      // T+3: reset taken
    check("rm_rst_htrans",  32'(HTRANS),    32'd0);
    check("rm_rst_haddr",   HADDR,          32'd0);
    check("rm_rst_hwdata",  HWDATA,         32'd0);
    check("rm_rst_ctrl",    32'({HWRITE, HSIZE, HBURST}), 32'd0);
    check("rm_rst_local",   32'({wr_ready, rd_valid, done, err}), 32'd0);
    check("rm_rst_cmd_rdy", 32'(cmd_ready), 32'd1);
    HRESET = 1'b0;
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rm_quiet_status", 32'({done, err, rd_valid}), 32'd0);
      check("rm_quiet_htrans", 32'(HTRANS), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
